// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide single-port data memory: sub-word stores use read-modify-write.
// Optional LSU_MISALIGN_ERR_EN turns misaligned halfword/word accesses into error responses.
module lsu_mem_master #(
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_req_valid_i,
  output logic        s_req_ready_o,
  input  logic        s_req_we_i,
  input  logic [2:0]  s_req_funct3_i,
  input  logic [31:0] s_req_addr_i,
  input  logic [31:0] s_req_wdata_i,
  output logic        s_resp_valid_o,
  output logic [31:0] s_resp_rdata_o,
  output logic        s_resp_err_o,
  output logic [31:0] m_add_o,
  output logic [31:0] m_val_o,
  output logic        m_write_o,
  input  logic [31:0] m_val_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    RESP
  } state_t;

  localparam logic [31:0] ADDR_LIMIT_W = 32'(ADDR_LIMIT);

  state_t      state;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [1:0]  req_lane;
  logic [15:0] req_wdata;
  logic        req_err;
  logic        misalign_err;

`ifdef LSU_MISALIGN_ERR_EN
  assign misalign_err = ((s_req_funct3_i[1:0] == 2'b01) && s_req_addr_i[0]) ||
                        ((s_req_funct3_i[1:0] == 2'b10) && (s_req_addr_i[1:0] != 2'b00));
`else
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    req_err = 1'b0;
    if ((s_req_funct3_i == 3'b011) || (s_req_funct3_i == 3'b110) || (s_req_funct3_i == 3'b111))
      req_err = 1'b1;
    if (s_req_we_i && s_req_funct3_i[2])
      req_err = 1'b1;
    if (s_req_addr_i >= ADDR_LIMIT_W)
      req_err = 1'b1;
    if (misalign_err)
      req_err = 1'b1;
  end

  assign s_req_ready_o = (state == IDLE);

  // Little-endian lane extract with sign or zero extension chosen by funct3[2].
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] funct3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] data,
                                              input logic [2:0] funct3, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    if (funct3[1:0] == 2'b00) begin
      case (lane)
        2'd0: r[7:0]   = data[7:0];
        2'd1: r[15:8]  = data[7:0];
        2'd2: r[23:16] = data[7:0];
        2'd3: r[31:24] = data[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = data;
    end else begin
      r[15:0] = data;
    end
    return r;
  endfunction

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      state          <= IDLE;
      req_we         <= 1'b0;
      req_funct3     <= 3'b000;
      req_lane       <= 2'b00;
      req_wdata      <= 16'h0000;
      s_resp_valid_o <= 1'b0;
      s_resp_rdata_o <= 32'h0;
      s_resp_err_o   <= 1'b0;
      m_add_o        <= 32'h0;
      m_val_o        <= 32'h0;
      m_write_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_req_valid_i) begin
            req_we     <= s_req_we_i;
            req_funct3 <= s_req_funct3_i;
            req_lane   <= s_req_addr_i[1:0];
            req_wdata  <= s_req_wdata_i[15:0];
            if (req_err) begin
              state          <= RESP;
              s_resp_valid_o <= 1'b1;
              s_resp_rdata_o <= 32'h0;
              s_resp_err_o   <= 1'b1;
            end else if (s_req_we_i && (s_req_funct3_i == 3'b010)) begin
              state     <= WR_ADDR;
              m_add_o   <= {s_req_addr_i[31:2], 2'b00};
              m_val_o   <= s_req_wdata_i;
              m_write_o <= 1'b1;
            end else begin
              state     <= RD_REQ;
              m_add_o   <= {s_req_addr_i[31:2], 2'b00};
              m_write_o <= 1'b0;
            end
          end
        end
        RD_REQ: state <= RD_DATA;
        // Loads finish here; sub-word stores fold their lane into the fetched word.
        RD_DATA: begin
          if (!req_we) begin
            state          <= RESP;
            s_resp_valid_o <= 1'b1;
            s_resp_rdata_o <= load_extract(m_val_i, req_funct3, req_lane);
            s_resp_err_o   <= 1'b0;
          end else begin
            state     <= WR_ADDR;
            m_val_o   <= merge_store(m_val_i, req_wdata, req_funct3, req_lane);
            m_write_o <= 1'b1;
          end
        end
        WR_ADDR: begin
          state     <= WR_DATA;
          m_write_o <= 1'b0;
        end
        WR_DATA: begin
          state          <= RESP;
          s_resp_valid_o <= 1'b1;
          s_resp_rdata_o <= 32'h0;
          s_resp_err_o   <= 1'b0;
        end
        RESP: begin
          state          <= IDLE;
          s_resp_valid_o <= 1'b0;
          s_resp_rdata_o <= 32'h0;
          s_resp_err_o   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized self-checking bench for lsu_mem_master against a byte-array reference model.
// Honours LSU_MISALIGN_ERR_EN the same way the design does.
module tb_lsu_mem_master;

  logic        s_clk_i = 1'b0;
  logic        s_reset_i;
  logic        s_req_valid_i;
  logic        s_req_ready_o;
  logic        s_req_we_i;
  logic [2:0]  s_req_funct3_i;
  logic [31:0] s_req_addr_i;
  logic [31:0] s_req_wdata_i;
  logic        s_resp_valid_o;
  logic [31:0] s_resp_rdata_o;
  logic        s_resp_err_o;
  logic [31:0] m_add_o;
  logic [31:0] m_val_o;
  logic        m_write_o;
  logic [31:0] m_val_i;

  lsu_mem_master #(.ADDR_LIMIT(4096)) dut (
    .s_clk_i(s_clk_i), .s_reset_i(s_reset_i),
    .s_req_valid_i(s_req_valid_i), .s_req_ready_o(s_req_ready_o),
    .s_req_we_i(s_req_we_i), .s_req_funct3_i(s_req_funct3_i),
    .s_req_addr_i(s_req_addr_i), .s_req_wdata_i(s_req_wdata_i),
    .s_resp_valid_o(s_resp_valid_o), .s_resp_rdata_o(s_resp_rdata_o),
    .s_resp_err_o(s_resp_err_o), .m_add_o(m_add_o), .m_val_o(m_val_o),
    .m_write_o(m_write_o), .m_val_i(m_val_i)
  );

  always #5 s_clk_i = ~s_clk_i;

  // Memory device: registered address/strobe, write data taken the cycle after the strobe.
  logic [31:0] dev_mem [0:1023];
  logic [31:0] mem_addr_q = 32'h0;
  logic        mem_we_q = 1'b0;
  always @(posedge s_clk_i) begin
    mem_addr_q <= m_add_o;
    mem_we_q   <= m_write_o;
    if (mem_we_q) dev_mem[mem_addr_q[11:2]] <= m_val_o;
  end
  assign m_val_i = dev_mem[mem_addr_q[11:2]];

  logic [7:0]  ref_mem [0:4095];
  int          n_errors = 0;
  int          n_checks = 0;
  bit          txn_active = 1'b0;
  bit          manual = 1'b0;
  int          cyc, writes, exp_lat, exp_writes;
  logic        exp_err;
  logic [31:0] exp_rdata, exp_waddr, exp_wword;
  bit          hold_chk;
  logic [31:0] held_add, held_val;
  logic [31:0] last_rdata, last_waddr;
  logic        last_err;
  int          last_lat;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed memory, access size from funct3, result from the access rules.
  task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int size, ea, wa;
    bit bad;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]) || (addr >= 32'd4096);
`ifdef LSU_MISALIGN_ERR_EN
    if ((addr % size) != 0) bad = 1'b1;
`endif
    exp_err = bad; exp_rdata = 32'h0; exp_writes = 0; exp_waddr = 32'h0; exp_wword = 32'h0;
    if (bad) begin
      exp_lat = 1;
    end else begin
      ea = int'(addr[11:0]) - (int'(addr[11:0]) % size);
      if (!we) begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[ea + i]) << (8 * i));
        if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
        exp_rdata = v;
        exp_lat = 3;
      end else begin
        for (int i = 0; i < size; i++) ref_mem[ea + i] = wdata[8 * i +: 8];
        wa = ea - (ea % 4);
        exp_waddr = 32'(wa);
        exp_wword = {ref_mem[wa + 3], ref_mem[wa + 2], ref_mem[wa + 1], ref_mem[wa]};
        exp_writes = 1;
        exp_lat = (size == 4) ? 3 : 5;
      end
    end
  endtask

  // Single compare process: checks every cycle of a transaction against the prediction.
  always @(negedge s_clk_i) begin
    if (!s_reset_i) begin
      if (txn_active) begin
        cyc++;
        check_output("ready_busy", {31'b0, s_req_ready_o}, 32'h0);
        if (hold_chk) begin
          check_output("m_val_held", m_val_o, held_val);
          check_output("m_add_held", m_add_o, held_add);
          hold_chk = 1'b0;
        end
        if (m_write_o) begin
          writes++;
          check_output("m_add_write", m_add_o, exp_waddr);
          check_output("m_val_write", m_val_o, exp_wword);
          held_add = m_add_o; held_val = m_val_o; hold_chk = 1'b1;
          last_waddr = m_add_o;
        end
        if (s_resp_valid_o) begin
          check_output("resp_latency", 32'(cyc), 32'(exp_lat));
          check_output("resp_err", {31'b0, s_resp_err_o}, {31'b0, exp_err});
          check_output("resp_rdata", s_resp_rdata_o, exp_rdata);
          check_output("write_count", 32'(writes), 32'(exp_writes));
          last_rdata = s_resp_rdata_o; last_err = s_resp_err_o; last_lat = cyc;
          txn_active = 1'b0;
        end else if (cyc > 12) begin
          check_output("resp_timeout", 32'(cyc), 32'(exp_lat));
          txn_active = 1'b0;
        end
      end else if (!manual) begin
        check_output("idle_quiet", {30'b0, s_resp_valid_o, m_write_o}, 32'h0);
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 once it is idle again.
  task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata);
    predict(we, f3, addr, wdata);
    last_rdata = 32'hBAD0_BAD0; last_err = 1'bx; last_lat = -1; last_waddr = 32'hBAD0_BAD0;
    check_output("ready_idle", {31'b0, s_req_ready_o}, 32'h1);
    s_req_valid_i = 1'b1; s_req_we_i = we; s_req_funct3_i = f3;
    s_req_addr_i = addr; s_req_wdata_i = wdata;
    @(posedge s_clk_i); #1;
    s_req_valid_i = 1'b0; s_req_we_i = 1'($urandom); s_req_funct3_i = 3'($urandom);
    s_req_addr_i = $urandom; s_req_wdata_i = $urandom;
    cyc = 0; writes = 0; hold_chk = 1'b0; txn_active = 1'b1;
    for (int k = 0; k < 20 && txn_active; k++) @(posedge s_clk_i);
    if (txn_active) begin
      check_output("driver_timeout", 32'h1, 32'h0);
      txn_active = 1'b0;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dev_mem[i] = 32'h0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    s_reset_i = 1'b0; s_req_valid_i = 1'b0; s_req_we_i = 1'b0;
    s_req_funct3_i = 3'b000; s_req_addr_i = 32'h0; s_req_wdata_i = 32'h0;
    #2 s_reset_i = 1'b1;
    #3;
    check_output("rst_ready", {31'b0, s_req_ready_o}, 32'h1);
    check_output("rst_outputs", {29'b0, s_resp_valid_o, s_resp_err_o, m_write_o}, 32'h0);
    check_output("rst_rdata", s_resp_rdata_o, 32'h0);
    check_output("rst_m_add", m_add_o, 32'h0);
    check_output("rst_m_val", m_val_o, 32'h0);
    #17 s_reset_i = 1'b0;
    @(posedge s_clk_i); #1;

    apply_stimulus(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    check_output("t1_sw_lat", 32'(last_lat), 32'd3);
    check_output("t1_sw_addr", last_waddr, 32'h100);
    apply_stimulus(1'b0, 3'b010, 32'h100, 32'h0);
    check_output("t1_lw", last_rdata, 32'hDEADBEEF);

    apply_stimulus(1'b1, 3'b000, 32'h101, 32'h000000AA);
    check_output("t2_sb_lat", 32'(last_lat), 32'd5);
    apply_stimulus(1'b0, 3'b010, 32'h100, 32'h0);
    check_output("t2_word", last_rdata, 32'hDEADAAEF);
    apply_stimulus(1'b0, 3'b000, 32'h101, 32'h0);
    check_output("t2_lb", last_rdata, 32'hFFFFFFAA);
    apply_stimulus(1'b0, 3'b100, 32'h101, 32'h0);
    check_output("t2_lbu", last_rdata, 32'h000000AA);

    apply_stimulus(1'b1, 3'b001, 32'h102, 32'h00008234);
    apply_stimulus(1'b0, 3'b010, 32'h100, 32'h0);
    check_output("t3_word", last_rdata, 32'h8234AAEF);
    apply_stimulus(1'b0, 3'b001, 32'h102, 32'h0);
    check_output("t3_lh", last_rdata, 32'hFFFF8234);
    apply_stimulus(1'b0, 3'b101, 32'h102, 32'h0);
    check_output("t3_lhu", last_rdata, 32'h00008234);

    apply_stimulus(1'b0, 3'b010, 32'h103, 32'h0);
`ifdef LSU_MISALIGN_ERR_EN
    check_output("t4_err", {31'b0, last_err}, 32'h1);
    check_output("t4_lat", 32'(last_lat), 32'd1);
    check_output("t4_rdata", last_rdata, 32'h0);
`else
    check_output("t4_err", {31'b0, last_err}, 32'h0);
    check_output("t4_rdata", last_rdata, 32'h8234AAEF);
`endif

    apply_stimulus(1'b0, 3'b010, 32'h1000, 32'h0);
    check_output("t5_limit_err", {31'b0, last_err}, 32'h1);
    check_output("t5_limit_lat", 32'(last_lat), 32'd1);
    apply_stimulus(1'b0, 3'b011, 32'h100, 32'h0);
    check_output("t5_f3_err", {31'b0, last_err}, 32'h1);
    apply_stimulus(1'b1, 3'b100, 32'h100, 32'h55);
    check_output("t5_sbu_err", {31'b0, last_err}, 32'h1);

    // Interrupted store writes the value already present, so memory is the same either way.
    apply_stimulus(1'b1, 3'b000, 32'h105, 32'h5A);
    manual = 1'b1;
    s_req_valid_i = 1'b1; s_req_we_i = 1'b1; s_req_funct3_i = 3'b000;
    s_req_addr_i = 32'h105; s_req_wdata_i = 32'h5A;
    @(posedge s_clk_i); #1;
    s_req_valid_i = 1'b0;
    @(posedge s_clk_i); @(posedge s_clk_i); #2;
    check_output("t6_pre_mwrite", {31'b0, m_write_o}, 32'h1);
    s_reset_i = 1'b1; #1;
    check_output("t6_mwrite_drop", {31'b0, m_write_o}, 32'h0);
    check_output("t6_ready_rst", {31'b0, s_req_ready_o}, 32'h1);
    repeat (2) begin
      @(negedge s_clk_i);
      check_output("t6_no_resp", {30'b0, s_resp_valid_o, m_write_o}, 32'h0);
    end
    @(posedge s_clk_i); #2 s_reset_i = 1'b0;
    repeat (3) begin
      @(negedge s_clk_i);
      check_output("t6_quiet", {30'b0, s_resp_valid_o, m_write_o}, 32'h0);
    end
    @(posedge s_clk_i); #1;
    manual = 1'b0;
    apply_stimulus(1'b0, 3'b010, 32'h104, 32'h0);
    check_output("t6_lw_after", last_rdata, 32'h00005A00);

    for (int n = 0; n < 200; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          r;
      we = 1'($urandom);
      r = $urandom_range(0, 9);
      if (r < 8) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom);
      end
      r = $urandom_range(0, 9);
      if (r < 7)       addr = 32'h200 + 32'($urandom_range(0, 63));
      else if (r == 7) addr = 32'd4090 + 32'($urandom_range(0, 11));
      else if (r == 8) addr = 32'hFFFF_0000 | 32'($urandom);
      else             addr = 32'($urandom_range(0, 4095));
      apply_stimulus(we, f3, addr, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
